// File: rtl/b_format_uop_decoder.sv
// B-form branch decoder: registers the instruction fields and cracks CTR-decrementing branches into two micro-ops.
// Optional branch-target computation is enabled by defining BFORMAT_TARGET_CALC_EN.
module b_format_uop_decoder #(
   parameter int addressWidth            = 64,
   parameter int instructionWidth        = 32,
   parameter int PidSize                 = 20,
   parameter int TidSize                 = 16,
   parameter int instructionCounterWidth = 64,
   parameter int instMinIdWidth          = 7,
   parameter int opcodeSize              = 6,
   parameter int regSize                 = 5,
   parameter int immediateSize           = 14,
   parameter int formatWidth             = 26,
   parameter int BFormatBit              = 1,
   parameter int BOpcode                 = 16,
   parameter int funcUnitCodeSize        = 3,
   parameter int FXUnitId                = 0,
   parameter int BranchUnitId            = 5
) (
   input  logic                               clock_i,
   input  logic                               reset_n_i,
   input  logic                               enable_i,
   input  logic                               stall_i,
   input  logic [formatWidth-1:0]             instFormat_i,
   input  logic [opcodeSize-1:0]              instructionOpcode_i,
   input  logic [instructionWidth-1:0]        instruction_i,
   input  logic [addressWidth-1:0]            instructionAddress_i,
   input  logic [PidSize-1:0]                 instructionPid_i,
   input  logic [TidSize-1:0]                 instructionTid_i,
   input  logic [instructionCounterWidth-1:0] instructionMajId_i,
   output logic                               busy_o,
   output logic                               enable_o,
   output logic                               invalidOp_o,
   output logic [opcodeSize-1:0]              instructionOpcode_o,
   output logic [addressWidth-1:0]            instructionAddress_o,
   output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
   output logic [instructionCounterWidth-1:0] instMajId_o,
   output logic [instMinIdWidth-1:0]          instMinId_o,
   output logic [PidSize-1:0]                 instPid_o,
   output logic [TidSize-1:0]                 instTid_o,
   output logic [regSize-1:0]                 BO_o,
   output logic [regSize-1:0]                 BI_o,
   output logic [immediateSize-1:0]           BD_o,
   output logic                               AA_o,
   output logic                               LK_o,
   output logic                               ctrDec_o,
   output logic                               uopIsLast_o,
   output logic [addressWidth-1:0]            targetAddress_o
);

   // Instruction bits are numbered MSB-first (bit 0 = MSB); MSB_POS maps that numbering onto vector indices.
   localparam int MSB_POS = instructionWidth - 1;

   typedef enum logic {IDLE, EMIT_BR} state_t;

   state_t                               state_q, state_d;
   logic                                 enable_q, enable_d;
   logic                                 invalid_q, invalid_d;
   logic [opcodeSize-1:0]                opcode_q, opcode_d;
   logic [addressWidth-1:0]              addr_q, addr_d;
   logic [funcUnitCodeSize-1:0]          fu_q, fu_d;
   logic [instructionCounterWidth-1:0]   maj_q, maj_d;
   logic [instMinIdWidth-1:0]            min_q, min_d;
   logic [PidSize-1:0]                   pid_q, pid_d;
   logic [TidSize-1:0]                   tid_q, tid_d;
   logic [regSize-1:0]                   bo_q, bo_d, bi_q, bi_d;
   logic [immediateSize-1:0]             bd_q, bd_d;
   logic                                 aa_q, aa_d, lk_q, lk_d;
   logic                                 ctr_q, ctr_d, last_q, last_d;
   logic                                 accept;

   assign accept = (state_q == IDLE) && !stall_i && enable_i && instFormat_i[BFormatBit]
                   && (instructionOpcode_i == opcodeSize'(BOpcode));

   always_comb begin
      state_d   = state_q;
      enable_d  = enable_q;
      invalid_d = invalid_q;
      opcode_d  = opcode_q;
      addr_d    = addr_q;
      fu_d      = fu_q;
      maj_d     = maj_q;
      min_d     = min_q;
      pid_d     = pid_q;
      tid_d     = tid_q;
      bo_d      = bo_q;
      bi_d      = bi_q;
      bd_d      = bd_q;
      aa_d      = aa_q;
      lk_d      = lk_q;
      ctr_d     = ctr_q;
      last_d    = last_q;
      if (!stall_i) begin
         enable_d  = 1'b0;
         invalid_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  enable_d = 1'b1;
                  opcode_d = instructionOpcode_i;
                  addr_d   = instructionAddress_i;
                  maj_d    = instructionMajId_i;
                  min_d    = '0;
                  pid_d    = instructionPid_i;
                  tid_d    = instructionTid_i;
                  bo_d     = instruction_i[MSB_POS-6 -: regSize];
                  bi_d     = instruction_i[MSB_POS-11 -: regSize];
                  bd_d     = instruction_i[MSB_POS-16 -: immediateSize];
                  aa_d     = instruction_i[MSB_POS-30];
                  lk_d     = instruction_i[MSB_POS-31];
                  // BO[2]=0 means the branch decrements CTR, so crack it into FX + branch micro-ops
                  if (instruction_i[MSB_POS-8]) begin
                     fu_d   = funcUnitCodeSize'(BranchUnitId);
                     ctr_d  = 1'b0;
                     last_d = 1'b1;
                  end else begin
                     fu_d    = funcUnitCodeSize'(FXUnitId);
                     ctr_d   = 1'b1;
                     last_d  = 1'b0;
                     state_d = EMIT_BR;
                  end
               end else if (enable_i && instFormat_i[BFormatBit]) begin
                  invalid_d = 1'b1;
               end
            end
            EMIT_BR: begin
               enable_d = 1'b1;
               fu_d     = funcUnitCodeSize'(BranchUnitId);
               min_d    = instMinIdWidth'(1);
               ctr_d    = 1'b0;
               last_d   = 1'b1;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= IDLE;
         enable_q  <= 1'b0;
         invalid_q <= 1'b0;
         opcode_q  <= '0;
         addr_q    <= '0;
         fu_q      <= '0;
         maj_q     <= '0;
         min_q     <= '0;
         pid_q     <= '0;
         tid_q     <= '0;
         bo_q      <= '0;
         bi_q      <= '0;
         bd_q      <= '0;
         aa_q      <= 1'b0;
         lk_q      <= 1'b0;
         ctr_q     <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         enable_q  <= enable_d;
         invalid_q <= invalid_d;
         opcode_q  <= opcode_d;
         addr_q    <= addr_d;
         fu_q      <= fu_d;
         maj_q     <= maj_d;
         min_q     <= min_d;
         pid_q     <= pid_d;
         tid_q     <= tid_d;
         bo_q      <= bo_d;
         bi_q      <= bi_d;
         bd_q      <= bd_d;
         aa_q      <= aa_d;
         lk_q      <= lk_d;
         ctr_q     <= ctr_d;
         last_q    <= last_d;
      end
   end

`ifdef BFORMAT_TARGET_CALC_EN
   logic [addressWidth-1:0] target_q, target_d, disp_sext;

   // Displacement is BD||0b00, sign-extended to the address width
   assign disp_sext = {{(addressWidth-immediateSize-2){instruction_i[MSB_POS-16]}},
                       instruction_i[MSB_POS-16 -: immediateSize], 2'b00};

   always_comb begin
      target_d = target_q;
      if (accept) begin
         target_d = instruction_i[MSB_POS-30] ? disp_sext : (instructionAddress_i + disp_sext);
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) target_q <= '0;
      else            target_q <= target_d;
   end

   assign targetAddress_o = target_q;
`else
   assign targetAddress_o = '0;
`endif

   assign busy_o               = (state_q == EMIT_BR);
   assign enable_o             = enable_q;
   assign invalidOp_o          = invalid_q;
   assign instructionOpcode_o  = opcode_q;
   assign instructionAddress_o = addr_q;
   assign functionalUnitType_o = fu_q;
   assign instMajId_o          = maj_q;
   assign instMinId_o          = min_q;
   assign instPid_o            = pid_q;
   assign instTid_o            = tid_q;
   assign BO_o                 = bo_q;
   assign BI_o                 = bi_q;
   assign BD_o                 = bd_q;
   assign AA_o                 = aa_q;
   assign LK_o                 = lk_q;
   assign ctrDec_o             = ctr_q;
   assign uopIsLast_o          = last_q;

endmodule

// File: doc/b_format_uop_decoder.md
Name: b_format_uop_decoder

Overview:
- Next-generation decoder for B-form (bc/bca/bcl/bcla) branch instructions, driven by the format pre-decoder.
- Registers all fields and cracks CTR-decrementing branches (BO[2]=0) into two micro-ops: a CTR decrement for the FX unit, then a conditional branch for the branch unit.
- Supports stall/busy backpressure.
- Sits between the format pre-decoder and the dispatch/ID stage.

Parameters:
- addressWidth, 64, instruction address width
- instructionWidth, 32, instruction width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID width
- instMinIdWidth, 7, minor ID width
- opcodeSize, 6, primary opcode width
- regSize, 5, BO/BI field width
- immediateSize, 14, BD field width
- formatWidth, 26, one-hot format vector width
- BFormatBit, 1, index of the B-form bit in instFormat_i
- BOpcode, 16, primary opcode for B-form
- funcUnitCodeSize, 3, functional unit code width
- FXUnitId, 0, integer unit code
- BranchUnitId, 5, branch unit code

Ports:
- clock_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- enable_i  in  1  input valid
- stall_i  in  1  downstream stall; freezes the block
- instFormat_i  in  formatWidth  one-hot format vector
- instructionOpcode_i  in  opcodeSize  primary opcode
- instruction_i  in  instructionWidth  raw instruction, bit 0 = MSB
- instructionAddress_i  in  addressWidth  instruction address
- instructionPid_i  in  PidSize  process ID
- instructionTid_i  in  TidSize  thread ID
- instructionMajId_i  in  instructionCounterWidth  major ID
- busy_o  out  1  high while the second micro-op is pending; upstream must hold its input
- enable_o  out  1  output micro-op valid
- invalidOp_o  out  1  one-cycle pulse: B-form bit set but opcode != BOpcode
- instructionOpcode_o  out  opcodeSize  opcode
- instructionAddress_o  out  addressWidth  address
- functionalUnitType_o  out  funcUnitCodeSize  target unit
- instMajId_o  out  instructionCounterWidth  major ID
- instMinId_o  out  instMinIdWidth  minor ID
- instPid_o  out  PidSize  process ID
- instTid_o  out  TidSize  thread ID
- BO_o  out  regSize  BO field, instruction[6:10]
- BI_o  out  regSize  BI field, instruction[11:15]
- BD_o  out  immediateSize  BD field, instruction[16:29]
- AA_o  out  1  instruction[30]
- LK_o  out  1  instruction[31]
- ctrDec_o  out  1  micro-op is the CTR decrement
- uopIsLast_o  out  1  last micro-op of this major ID
- targetAddress_o  out  addressWidth  branch target (optional feature only)

Behaviour:
- Reset (async, reset_n_i=0): every output = 0; state = IDLE. Applies immediately, including mid-crack; a pending second micro-op is discarded.
- States:
  - IDLE
  - EMIT_BR: CTR micro-op issued, branch micro-op pending.
- busy_o = (state == EMIT_BR), registered.
- stall_i=1 takes priority over everything: all outputs and state hold; inputs ignored.
- Accept condition: state IDLE, stall_i=0, enable_i=1, instFormat_i[BFormatBit]=1, instructionOpcode_i == BOpcode.
  - Latency: 1 clock.
  - Header and BO/BI/BD/AA/LK captured.
  - enable_o=1.
- Accept with BO[2] (instruction[8]) = 1:
  - single micro-op: FU=BranchUnitId, minId=0, ctrDec_o=0, uopIsLast_o=1.
  - state stays IDLE.
- Accept with BO[2] = 0:
  - emits CTR micro-op: FU=FXUnitId, minId=0, ctrDec_o=1, uopIsLast_o=0; state → EMIT_BR.
  - Next unstalled cycle: emits branch micro-op from the held fields: FU=BranchUnitId, minId=1, ctrDec_o=0, uopIsLast_o=1; state → IDLE.
  - Inputs are ignored while in EMIT_BR.
- B-form bit set with a wrong opcode (IDLE, unstalled): invalidOp_o=1 for one cycle; enable_o=0.
- Any other unstalled cycle with no emission: enable_o=0, invalidOp_o=0; data outputs hold their last values.
- Minor ID is zero-extended to instMinIdWidth.

Optional Feature:
- Macro: BFORMAT_TARGET_CALC_EN.
- When defined: targetAddress_o is registered alongside the micro-op.
  - BD||0b00 is sign-extended to addressWidth.
  - AA=1: target = sign-extended value.
  - AA=0: target = instructionAddress_i + sign-extended value, modulo 2^addressWidth.
  - Target is valid on both micro-ops of a cracked pair.
- When undefined: targetAddress_o is tied to 0 and no adder is synthesised.

Test Plan:
- Single micro-op: inst 0x4182000C, addr 0x1000, majId 5, format bit set, opcode 16 -> next cycle:
  - enable_o=1, BO=12, BI=2, BD=3, AA=0, LK=0;
  - FU=5, minId=0, uopIsLast=1, busy_o=0;
  - with BFORMAT_TARGET_CALC_EN: target=0x100C.
- Crack: inst 0x4200FFF8 (bdnz -8), addr 0x2000 ->
  - cycle 1: FU=0, ctrDec=1, minId=0, busy_o=1;
  - cycle 2: FU=5, minId=1, uopIsLast=1, busy_o=0;
  - with BFORMAT_TARGET_CALC_EN: target=0x1FF8 on both micro-ops.
- Stall during EMIT_BR: assert stall_i for 3 cycles after the CTR micro-op -> outputs frozen at minId 0; the branch micro-op emits on the first unstalled edge.
- Bad opcode: format bit set, opcode 18 -> invalidOp_o pulses one cycle; enable_o=0.
- Async reset in EMIT_BR: drop reset_n_i between clock edges -> all outputs 0 immediately; after release, a new instruction is accepted normally.
- AA=1 absolute: inst 0x41820012 -> AA_o=1; with BFORMAT_TARGET_CALC_EN: target=0x10 regardless of address.
